// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the GPIO config decoder: opcodes, command-word field
// positions and FSM state encoding.
package gpio_cfg_pkg;

  localparam logic [3:0] OP_IDX         = 4'h1;
  localparam logic [3:0] OP_GAIN        = 4'h2;
  localparam logic [3:0] OP_IDX_COMMIT  = 4'h3;
  localparam logic [3:0] OP_GAIN_COMMIT = 4'h4;
  localparam logic [3:0] OP_GAIN_ALL    = 4'h5;
  localparam logic [3:0] OP_SAFE        = 4'hC;
  localparam logic [3:0] OP_COMMIT      = 4'hF;

  localparam int CMD_HI  = 31;
  localparam int CMD_LO  = 28;
  localparam int ADDR_HI = 27;
  localparam int ADDR_LO = 20;
  localparam int DATA_HI = 19;
  localparam int DATA_LO = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_EXEC   = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;
  localparam state_t ST_BCAST  = 2'd3;

  function automatic logic is_known_op(input logic [3:0] op);
    return (op == OP_IDX) || (op == OP_GAIN) || (op == OP_IDX_COMMIT) ||
           (op == OP_GAIN_COMMIT) || (op == OP_GAIN_ALL) ||
           (op == OP_SAFE) || (op == OP_COMMIT);
  endfunction

endpackage

// File: rtl/gpio_cfg_cmd_fifo.sv
// Synchronous command FIFO; a push is honoured while full when a pop happens
// on the same edge.
module gpio_cfg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PW+1)'(1);
      if (do_pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/gpio_cfg_decoder_axis_mc.sv
// AXI-Stream command decoder driving GPIO index/gain/commit/safe writes.
// Optional saturating error counter enabled by GPIO_CFG_ERRCNT_EN.
module gpio_cfg_decoder_axis_mc
  import gpio_cfg_pkg::*;
#(
  parameter int IDX_W      = 10,
  parameter int GAIN_W     = 18,
  parameter int CH_W       = 1,
  parameter int TONE_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              idx_we,
  output logic              gain_we,
  output logic              commit_req,
  output logic              safe_we,
  output logic [CH_W-1:0]   wr_ch,
  output logic [TONE_W-1:0] wr_tone,
  output logic [IDX_W-1:0]  wr_index,
  output logic [GAIN_W-1:0] wr_gain,
  output logic              safe_val,
  output logic              busy
`ifdef GPIO_CFG_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int AW = CH_W + TONE_W;

  state_t        state;
  logic [31:0]   cur, fifo_dout;
  logic [3:0]    op;
  logic [7:0]    addr;
  logic [19:0]   data;
  logic [AW-1:0] cnt;
  logic          fifo_full, fifo_empty, push, pop, ready_en;
  logic          unused_fields;

  assign op   = cur[CMD_HI:CMD_LO];
  assign addr = cur[ADDR_HI:ADDR_LO];
  assign data = cur[DATA_HI:DATA_LO];
  assign unused_fields = ^{addr, data};

  // ready_en keeps tready low through reset and rises on the first edge after.
  assign s_axis_tready = ready_en & ~fifo_full;
  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = (state == ST_IDLE) & ~fifo_empty;
  assign busy = (state != ST_IDLE) | ~fifo_empty;

  gpio_cfg_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (s_axis_tdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      cnt        <= '0;
      ready_en   <= 1'b0;
      idx_we     <= 1'b0;
      gain_we    <= 1'b0;
      commit_req <= 1'b0;
      safe_we    <= 1'b0;
      wr_ch      <= '0;
      wr_tone    <= '0;
      wr_index   <= '0;
      wr_gain    <= '0;
      safe_val   <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      idx_we     <= 1'b0;
      gain_we    <= 1'b0;
      commit_req <= 1'b0;
      safe_we    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur   <= fifo_dout;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          case (op)
            OP_IDX, OP_IDX_COMMIT: begin
              idx_we   <= 1'b1;
              wr_ch    <= addr[AW-1:TONE_W];
              wr_tone  <= addr[TONE_W-1:0];
              wr_index <= data[IDX_W-1:0];
              if (op == OP_IDX_COMMIT) state <= ST_COMMIT;
            end
            OP_GAIN, OP_GAIN_COMMIT: begin
              gain_we <= 1'b1;
              wr_ch   <= addr[AW-1:TONE_W];
              wr_tone <= addr[TONE_W-1:0];
              wr_gain <= data[GAIN_W-1:0];
              if (op == OP_GAIN_COMMIT) state <= ST_COMMIT;
            end
            OP_GAIN_ALL: begin
              // Address 0 is written here; BCAST covers 1..last.
              gain_we          <= 1'b1;
              {wr_ch, wr_tone} <= '0;
              wr_gain          <= data[GAIN_W-1:0];
              cnt              <= AW'(1);
              state            <= ST_BCAST;
            end
            OP_SAFE: begin
              safe_we  <= 1'b1;
              safe_val <= data[0];
            end
            OP_COMMIT: commit_req <= safe_val;
            default: ;
          endcase
        end
        ST_COMMIT: begin
          commit_req <= safe_val;
          state      <= ST_IDLE;
        end
        ST_BCAST: begin
          gain_we          <= 1'b1;
          {wr_ch, wr_tone} <= cnt;
          cnt              <= cnt + AW'(1);
          if (&cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GPIO_CFG_ERRCNT_EN
  logic err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (state == ST_EXEC)
      err_hit = !is_known_op(op) || ((op == OP_COMMIT) && !safe_val);
    else if (state == ST_COMMIT)
      err_hit = !safe_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (err_hit && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_gpio_cfg_decoder_axis_mc.sv
// Self-checking bench: randomized and directed command streams scored against
// an in-order event model of the decoder.
module tb_gpio_cfg_decoder_axis_mc;

  localparam int IDX_W  = 10;
  localparam int GAIN_W = 18;
  localparam int CH_W   = 1;
  localparam int TONE_W = 3;
  localparam int DEPTH  = 4;
  localparam int NADDR  = 1 << (CH_W + TONE_W);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              idx_we, gain_we, commit_req, safe_we;
  logic [CH_W-1:0]   wr_ch;
  logic [TONE_W-1:0] wr_tone;
  logic [IDX_W-1:0]  wr_index;
  logic [GAIN_W-1:0] wr_gain;
  logic              safe_val, busy;
`ifdef GPIO_CFG_ERRCNT_EN
  logic [15:0]       err_cnt;
`endif

  gpio_cfg_decoder_axis_mc #(
    .IDX_W(IDX_W), .GAIN_W(GAIN_W), .CH_W(CH_W), .TONE_W(TONE_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .idx_we(idx_we), .gain_we(gain_we), .commit_req(commit_req), .safe_we(safe_we),
    .wr_ch(wr_ch), .wr_tone(wr_tone), .wr_index(wr_index), .wr_gain(wr_gain),
    .safe_val(safe_val), .busy(busy)
`ifdef GPIO_CFG_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 idx, 1 gain, 2 commit, 3 safe
    logic [7:0]  addr;
    logic [19:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  bit  m_safe = 1'b0;
  int  m_err  = 0;

  function automatic ev_t mk(input int kind, input int a, input int v);
    ev_t e;
    e.kind = 2'(kind);
    e.addr = 8'(a);
    e.val  = 20'(v);
    return e;
  endfunction

  // Expected event stream of one command word, in execution order.
  function automatic void model(input logic [31:0] w);
    int op, a, d, di, dg;
    op = int'(w[31:28]);
    a  = int'(w[27:20]) % NADDR;
    d  = int'(w[19:0]);
    di = d % (1 << IDX_W);
    dg = d % (1 << GAIN_W);
    case (op)
      1, 3: exp_q.push_back(mk(0, a, di));
      2, 4: exp_q.push_back(mk(1, a, dg));
      5: for (int i = 0; i < NADDR; i++) exp_q.push_back(mk(1, i, dg));
      12: begin m_safe = w[0]; exp_q.push_back(mk(3, 0, int'(w[0]))); end
      15: ;
      default: m_err++;
    endcase
    if (op == 3 || op == 4 || op == 15) begin
      if (m_safe) exp_q.push_back(mk(2, 0, 0));
      else m_err++;
    end
  endfunction

  // Scoreboard: every pulse must match the next expected event.
  always @(negedge clk) begin
    int  np;
    ev_t o, e;
    if (rst_n) begin
      np = int'(idx_we) + int'(gain_we) + int'(commit_req) + int'(safe_we);
      if (np != 0) begin
        checks++;
        if (np > 1) $display("FAIL overlap: %0d pulses together, required 1", np);
        else passes++;
        o = '0;
        if (idx_we)     o = mk(0, int'({wr_ch, wr_tone}), int'(wr_index));
        if (gain_we)    o = mk(1, int'({wr_ch, wr_tone}), int'(wr_gain));
        if (commit_req) o = mk(2, 0, 0);
        if (safe_we)    o = mk(3, 0, int'(safe_val));
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse: got %h, none expected at %0t", o, $time);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) $display("FAIL event: got %h, required %h at %0t", o, e, $time);
          else passes++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n >= 500) $display("FAIL send_timeout: word %h not accepted, required accept", w);
    else begin passes++; model(w); end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    int n;
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    timed_out = (n >= 2000);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    m_safe = 1'b0;
    m_err  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {idx_we, gain_we, commit_req, safe_we, 8'(wr_ch), 8'(wr_tone),
            20'(wr_index), 20'(wr_gain)};
    checks++;
    if (outs !== 64'd0) $display("FAIL reset_outputs: got %h, required 0", outs);
    else passes++;
    checks++;
    if ({safe_val, busy, s_axis_tready} !== 3'b000)
      $display("FAIL reset_levels: got %b, required 000", {safe_val, busy, s_axis_tready});
    else passes++;
`ifdef GPIO_CFG_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'd0) $display("FAIL reset_errcnt: got %0d, required 0", err_cnt);
    else passes++;
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) $display("FAIL tready_before_edge: got %b, required 0", s_axis_tready);
    else passes++;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL tready_after_edge: got %b, required 1", s_axis_tready);
    else passes++;
  endtask

  task automatic test_idx_latency();
    bit to;
    send(32'h10A003FF);
    @(negedge clk);
    checks++;
    if (idx_we !== 1'b0) $display("FAIL idx_early: got %b, required 0", idx_we);
    else passes++;
    @(negedge clk);
    checks++;
    if ({idx_we, commit_req, 1'(wr_ch), 3'(wr_tone), 10'(wr_index)} !== {1'b1, 1'b0, 1'b1, 3'd2, 10'h3FF})
      $display("FAIL idx_pulse: got we=%b cr=%b ch=%0d tone=%0d idx=%h, required 1 0 1 2 3ff",
               idx_we, commit_req, wr_ch, wr_tone, wr_index);
    else passes++;
    drain(to);
    checks++;
    if (to || exp_q.size() != 0) $display("FAIL drain_idx: left %0d, required 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_gain_commit();
    int n;
    bit to;
    send(32'hC0000001);
    send(32'h40312345);
    n = 0;
    while (!gain_we && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!gain_we || commit_req || wr_gain !== 18'h12345)
      $display("FAIL gain_write: got we=%b cr=%b gain=%h, required 1 0 12345", gain_we, commit_req, wr_gain);
    else passes++;
    @(negedge clk);
    checks++;
    if (commit_req !== 1'b1 || gain_we !== 1'b0)
      $display("FAIL commit_follow: got cr=%b we=%b, required 1 0", commit_req, gain_we);
    else passes++;
    drain(to);
    checks++;
    if (to || exp_q.size() != 0) $display("FAIL drain_commit: left %0d, required 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_blocked_commit();
    bit to;
    do_reset();
    send(32'hC0000000);
    send(32'hF0000000);
    drain(to);
    checks++;
    if (to || exp_q.size() != 0 || safe_val !== 1'b0)
      $display("FAIL blocked: left %0d safe=%b, required 0 0", exp_q.size(), safe_val);
    else passes++;
`ifdef GPIO_CFG_ERRCNT_EN
    checks++;
    if (int'(err_cnt) != m_err || m_err != 1)
      $display("FAIL errcnt_blocked: got %0d, required 1", err_cnt);
    else passes++;
`endif
  endtask

  task automatic test_bcast();
    int n, run;
    bit stray, to;
    send(32'hC0000001);
    send(32'h50000100);
    send(32'h10177777);
    n = 0;
    while (!gain_we && n < 50) begin @(negedge clk); n++; end
    run = 0;
    stray = 1'b0;
    while (gain_we && run < 40) begin
      if (idx_we || commit_req || safe_we) stray = 1'b1;
      run++;
      @(negedge clk);
    end
    checks++;
    if (run != NADDR || stray) $display("FAIL bcast_run: got %0d stray=%b, required %0d 0", run, stray, NADDR);
    else passes++;
    drain(to);
    checks++;
    if (to || exp_q.size() != 0) $display("FAIL drain_bcast: left %0d, required 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[10];
    int i, n;
    bit acc, saw_low, to;
    send(32'hC0000001);
    for (int k = 0; k < 10; k++) w[k] = {4'h3, 8'($urandom), 20'($urandom)};
    i = 0; n = 0; saw_low = 1'b0;
    s_axis_tvalid = 1'b1;
    while (i < 10 && n < 1000) begin
      s_axis_tdata = w[i];
      acc = s_axis_tready;
      if (!acc) saw_low = 1'b1;
      @(negedge clk);
      n++;
      if (acc) begin model(w[i]); i++; end
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (i != 10 || !saw_low) $display("FAIL b2b_flow: accepted %0d backpressure=%b, required 10 1", i, saw_low);
    else passes++;
    drain(to);
    checks++;
    if (to || exp_q.size() != 0) $display("FAIL drain_b2b: left %0d, required 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_bcast();
    int n, cnt;
    send(32'h500ABCDE);
    n = 0;
    while (!(gain_we && {wr_ch, wr_tone} == 4'd5) && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (n >= 60) $display("FAIL bcast_addr5: never reached, required reach");
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({idx_we, gain_we, commit_req, safe_we, safe_val, s_axis_tready, busy} !== 7'd0 ||
        {wr_ch, wr_tone} !== 4'd0 || wr_gain !== '0 || wr_index !== '0)
      $display("FAIL reset_mid_bcast: gain_we=%b addr=%0d gain=%h, required all 0",
               gain_we, {wr_ch, wr_tone}, wr_gain);
    else passes++;
    exp_q.delete();
    m_safe = 1'b0;
    m_err  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      cnt += int'(idx_we) + int'(gain_we) + int'(commit_req) + int'(safe_we);
    end
    checks++;
    if (cnt != 0) $display("FAIL post_reset_pulses: got %0d, required 0", cnt);
    else passes++;
  endtask

  task automatic test_random();
    logic [3:0] ops[11];
    logic [31:0] w;
    bit to;
    ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hC, 4'hC, 4'hF, 4'h0, 4'h7, 4'hE};
    for (int k = 0; k < 40; k++) begin
      w = {ops[$urandom_range(0, 10)], 8'($urandom), 20'($urandom)};
      send(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(to);
    checks++;
    if (to || exp_q.size() != 0) $display("FAIL drain_random: left %0d, required 0", exp_q.size());
    else passes++;
`ifdef GPIO_CFG_ERRCNT_EN
    checks++;
    if (int'(err_cnt) != m_err) $display("FAIL errcnt_random: got %0d, required %0d", err_cnt, m_err);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_idx_latency();
    test_gain_commit();
    test_blocked_commit();
    test_bcast();
    test_back_to_back();
    test_reset_bcast();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
